// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
// BREAKPOINT_EN (optional macro) adds breakpoint ports and the skip flag in cpu_run_ctrl.
package cpu_run_ctrl_pkg;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned STATE_W = 3;

    localparam logic [OP_W-1:0] OP_JMP = 4'b1001;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD = 3'd0,
        ST_IDLE = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    typedef struct packed {
        logic clr;
        logic halt;
        logic step;
        logic run;
    } btn_pulse_t;

    // A jump whose target equals its own address means the CPU has stopped itself.
    function automatic logic is_self_jump(input logic [INSTR_W-1:0] instr,
                                          input logic [PC_W-1:0]    pc);
        return (instr[INSTR_W-1:PC_W] == OP_JMP) && (instr[PC_W-1:0] == pc);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer followed by a rising-edge detector producing a registered 1-cycle pulse.
module btn_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, btn});
            prev_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for a small CPU: button handling, CPU reset sequencing and cycle count.
// Optional macro BREAKPOINT_EN adds bp_addr/bp_valid and a PC breakpoint in RUN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYC     = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_btn,
    input  logic               step_btn,
    input  logic               halt_btn,
    input  logic               clr_btn,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
`ifdef BREAKPOINT_EN
    input  logic [PC_W-1:0]    bp_addr,
    input  logic               bp_valid,
`endif
    output logic               cpu_en,
    output logic               cpu_rst_n,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_cnt
);

    localparam int unsigned HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_d;
    btn_pulse_t        btn_p;
    logic              run_p, step_p, halt_p, clr_p;
    logic              bp_hit;
    logic              self_jmp;

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_run_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (run_btn),
        .pulse (run_p)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (step_btn),
        .pulse (step_p)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_halt_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (halt_btn),
        .pulse (halt_p)
    );

    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (clr_btn),
        .pulse (clr_p)
    );

    assign btn_p = '{clr: clr_p, halt: halt_p, step: step_p, run: run_p};

    assign self_jmp = (state_q == ST_RUN) && is_self_jump(instr, pc);

`ifdef BREAKPOINT_EN
    logic skip_q, skip_d;

    // Skip lets the breakpointed instruction execute once after resuming from HALT.
    assign bp_hit = (state_q == ST_RUN) && bp_valid && (pc == bp_addr) && !skip_q;

    always_comb begin
        skip_d = skip_q;
        if (state_d == ST_HOLD) begin
            skip_d = 1'b0;
        end else if ((state_q == ST_HALT) && ((state_d == ST_RUN) || (state_d == ST_STEP))) begin
            skip_d = 1'b1;
        end else if (cpu_en) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    // CPU-facing controls decode straight from the registered state.
    assign cpu_en    = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);
    assign cpu_rst_n = (state_q != ST_HOLD);
    assign halted    = (state_q == ST_HALT);
    assign state     = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state; clr overrides everything, then halt > step > run.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_IDLE, ST_HALT: begin
                if (btn_p.step) begin
                    state_d = ST_STEP;
                end else if (btn_p.run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_p.halt || bp_hit || self_jmp) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
        if (btn_p.clr) begin
            state_d = ST_HOLD;
            hold_d  = '0;
        end
    end

    // Enabled-cycle counter: saturating, zeroed on entry to and during HOLD.
    always_comb begin
        cnt_d = cycle_cnt;
        if (state_d == ST_HOLD) begin
            cnt_d = '0;
        end else if (cpu_en && (cycle_cnt != '1)) begin
            cnt_d = cycle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed scoreboard bench for cpu_run_ctrl; a second instance with CNT_W=4 checks saturation.
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_btn, step_btn, halt_btn, clr_btn;
    logic [3:0] pc;
    logic [7:0] instr;
`ifdef BREAKPOINT_EN
    logic [3:0] bp_addr;
    logic       bp_valid;
`endif
    logic        cpu_en, cpu_rst_n, halted;
    logic [2:0]  state;
    logic [15:0] cycle_cnt;
    logic        s_cpu_en, s_cpu_rst_n, s_halted;
    logic [2:0]  s_state;
    logic [3:0]  s_cycle_cnt;

    localparam logic [2:0] HOLD = 3'd0, IDLE = 3'd1, RUN = 3'd2, STEP = 3'd3, HALT = 3'd4;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_CYC(4), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .run_btn   (run_btn),
        .step_btn  (step_btn),
        .halt_btn  (halt_btn),
        .clr_btn   (clr_btn),
        .pc        (pc),
        .instr     (instr),
`ifdef BREAKPOINT_EN
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
`endif
        .cpu_en    (cpu_en),
        .cpu_rst_n (cpu_rst_n),
        .state     (state),
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
    );

    cpu_run_ctrl #(.RST_CYC(4), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .run_btn   (run_btn),
        .step_btn  (step_btn),
        .halt_btn  (halt_btn),
        .clr_btn   (clr_btn),
        .pc        (pc),
        .instr     (instr),
`ifdef BREAKPOINT_EN
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
`endif
        .cpu_en    (s_cpu_en),
        .cpu_rst_n (s_cpu_rst_n),
        .state     (s_state),
        .halted    (s_halted),
        .cycle_cnt (s_cycle_cnt)
    );

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty: observed %0h with no expected entry", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                mismatched++;
                $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    // Polls the state on negedges for up to budget cycles; a timeout shows as a state mismatch.
    task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
        int n;
        n = 0;
        sb_push(tag, 32'(tgt));
        while (state !== tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        sb_check(32'(state));
    endtask

    task automatic release_btns();
        run_btn  = 1'b0;
        step_btn = 1'b0;
        halt_btn = 1'b0;
        clr_btn  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        release_btns();
        pc    = 4'h0;
        instr = 8'h00;
`ifdef BREAKPOINT_EN
        bp_addr  = 4'h0;
        bp_valid = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset values
        expect_now("rst_state", 32'(HOLD), 32'(state));
        expect_now("rst_cpu_rst_n", 0, 32'(cpu_rst_n));
        expect_now("rst_cpu_en", 0, 32'(cpu_en));
        expect_now("rst_cnt", 0, 32'(cycle_cnt));
        expect_now("rst_halted", 0, 32'(halted));

        // Release: cpu_rst_n rises after the 4th clock
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            expect_now("hold_cpu_rst_n", 0, 32'(cpu_rst_n));
        end
        @(negedge clk);
        expect_now("rel_cpu_rst_n", 1, 32'(cpu_rst_n));
        expect_now("rel_state", 32'(IDLE), 32'(state));
        expect_now("rel_cnt", 0, 32'(cycle_cnt));

        // Single step from IDLE
        step_btn = 1'b1;
        wait_state(STEP, 10, "step_enter");
        step_btn = 1'b0;
        expect_now("step_cpu_en", 1, 32'(cpu_en));
        @(negedge clk);
        expect_now("step_state", 32'(HALT), 32'(state));
        expect_now("step_cpu_en_off", 0, 32'(cpu_en));
        expect_now("step_halted", 1, 32'(halted));
        expect_now("step_cnt", 1, 32'(cycle_cnt));
        repeat (3) @(negedge clk);
        expect_now("step_cnt_hold", 1, 32'(cycle_cnt));

        // Run exactly 20 enabled cycles, then halt
        run_btn = 1'b1;
        wait_state(RUN, 10, "run20_enter");
        run_btn = 1'b0;
        repeat (16) @(negedge clk);
        halt_btn = 1'b1;
        wait_state(HALT, 10, "run20_halt");
        halt_btn = 1'b0;
        expect_now("run20_cnt", 21, 32'(cycle_cnt));
        expect_now("sat_cnt", 32'h0000_000F, 32'(s_cycle_cnt));
        expect_now("run20_cpu_en", 0, 32'(cpu_en));
        repeat (4) @(negedge clk);

        // Self-jump at pc=A halts after one enabled cycle
        pc = 4'hA;
        run_btn = 1'b1;
        wait_state(RUN, 10, "sj_enter");
        run_btn = 1'b0;
        instr = 8'h9A;
        expect_now("sj_cpu_en", 1, 32'(cpu_en));
        @(negedge clk);
        instr = 8'h00;
        expect_now("sj_state", 32'(HALT), 32'(state));
        expect_now("sj_halted", 1, 32'(halted));
        expect_now("sj_cnt", 22, 32'(cycle_cnt));
        expect_now("sj_sat_cnt", 32'h0000_000F, 32'(s_cycle_cnt));
        repeat (4) @(negedge clk);

        // Same-cycle clr and run while running: clr wins
        run_btn = 1'b1;
        wait_state(RUN, 10, "clr_run_enter");
        run_btn = 1'b0;
        repeat (4) @(negedge clk);
        clr_btn = 1'b1;
        run_btn = 1'b1;
        wait_state(HOLD, 10, "clr_hold");
        release_btns();
        expect_now("clr_cnt", 0, 32'(cycle_cnt));
        expect_now("clr_sat_cnt", 0, 32'(s_cycle_cnt));
        for (int i = 0; i < 4; i++) begin
            expect_now("clr_cpu_rst_n_low", 0, 32'(cpu_rst_n));
            @(negedge clk);
        end
        expect_now("clr_cpu_rst_n_high", 1, 32'(cpu_rst_n));
        expect_now("clr_state_idle", 32'(IDLE), 32'(state));
        repeat (6) @(negedge clk);
        expect_now("clr_run_dropped", 32'(IDLE), 32'(state));

        // Halt pulse is ignored in IDLE
        halt_btn = 1'b1;
        repeat (8) @(negedge clk);
        halt_btn = 1'b0;
        expect_now("idle_halt_dropped", 32'(IDLE), 32'(state));
        expect_now("idle_cpu_en", 0, 32'(cpu_en));
        repeat (4) @(negedge clk);

`ifdef BREAKPOINT_EN
        // Breakpoint at pc=3: hit, then resume executes pc=3 once
        pc       = 4'h3;
        bp_addr  = 4'h3;
        bp_valid = 1'b1;
        run_btn  = 1'b1;
        wait_state(RUN, 10, "bp_enter");
        run_btn = 1'b0;
        expect_now("bp_hit_cpu_en", 0, 32'(cpu_en));
        @(negedge clk);
        expect_now("bp_hit_state", 32'(HALT), 32'(state));
        expect_now("bp_hit_cnt", 0, 32'(cycle_cnt));
        repeat (4) @(negedge clk);
        run_btn = 1'b1;
        wait_state(RUN, 10, "bp_resume");
        run_btn = 1'b0;
        expect_now("bp_skip_cpu_en", 1, 32'(cpu_en));
        pc = 4'h4;
        @(negedge clk);
        expect_now("bp_no_rehit_state", 32'(RUN), 32'(state));
        expect_now("bp_no_rehit_cpu_en", 1, 32'(cpu_en));
        expect_now("bp_resume_cnt", 1, 32'(cycle_cnt));
        bp_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
